// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory pipeline stage: LSU requests to OCP-style bus, load align/extend, writeback forward
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned HWORD/WORD access raises o_bus_err instead of a bus command)
module memory_access (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_exec_stall,
  input  logic        i_fetch_stall,
  output logic        o_mem_stall,
  input  logic [4:0]  i_rd_no,
  input  logic [31:0] i_alu_result,
  input  logic [1:0]  i_lsu_op,
  input  logic        i_lsu_lns,
  input  logic        i_lsu_ext,
  input  logic [31:0] i_mem_data,
  output logic [4:0]  o_rd_no,
  output logic [31:0] o_rd_val,
  output logic [31:0] o_MAddr,
  output logic [2:0]  o_MCmd,
  output logic [31:0] o_MData,
  output logic [3:0]  o_MByteEn,
  input  logic        i_SCmdAccept,
  input  logic [31:0] i_SData,
  input  logic [1:0]  i_SResp,
  output logic        o_bus_err
);

  localparam logic [1:0] LSU_IDLE  = 2'd0;
  localparam logic [1:0] LSU_BYTE  = 2'd1;
  localparam logic [1:0] LSU_HWORD = 2'd2;
  localparam logic [1:0] LSU_WORD  = 2'd3;

  localparam logic [2:0] MCMD_IDLE = 3'd0;
  localparam logic [2:0] MCMD_WR   = 3'd1;
  localparam logic [2:0] MCMD_RD   = 3'd2;

  localparam logic [1:0] SRESP_NULL = 2'd0;
  localparam logic [1:0] SRESP_DVA  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Captured transaction attributes, held for the whole bus transaction
  logic [4:0]  rd_q;
  logic [1:0]  op_q;
  logic        lns_q;
  logic        ext_q;
  logic [1:0]  a_q;

  // Bus-facing and writeback registers
  logic [31:0] maddr_q;
  logic [31:0] mdata_q;
  logic [3:0]  mbyteen_q;
  logic [4:0]  rd_no_q;
  logic [31:0] rd_val_q;
  logic        bus_err_q;

  logic        core_stall;
  logic        capture;
  logic        misalign;
  logic [1:0]  a;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [31:0] load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a          = i_alu_result[1:0];
  assign core_stall = i_exec_stall | i_fetch_stall | o_mem_stall;
  // Capture is only meaningful in IDLE; outside IDLE o_mem_stall already blocks it
  assign capture    = !core_stall;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((i_lsu_op == LSU_HWORD) && a[0]) ||
                    ((i_lsu_op == LSU_WORD) && (a != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Byte-lane enables and lane-replicated store data for the incoming request
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = i_mem_data;
    case (i_lsu_op)
      LSU_BYTE: begin
        lane_be   = 4'b0001 << a;
        lane_data = {4{i_mem_data[7:0]}};
      end
      LSU_HWORD: begin
        lane_be   = a[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_mem_data[15:0]}};
      end
      LSU_WORD: begin
        lane_be   = 4'b1111;
        lane_data = i_mem_data;
      end
      default: begin
        lane_be   = 4'b0000;
        lane_data = i_mem_data;
      end
    endcase
  end

  // Extract and sign/zero-extend load data from the response word
  always_comb begin
    ld_byte  = i_SData[{a_q, 3'b000} +: 8];
    ld_half  = i_SData[{a_q[1], 4'b0000} +: 16];
    load_val = i_SData;
    case (op_q)
      LSU_BYTE:  load_val = {{24{ext_q & ld_byte[7]}}, ld_byte};
      LSU_HWORD: load_val = {{16{ext_q & ld_half[15]}}, ld_half};
      default:   load_val = i_SData;
    endcase
  end

  // FSM state register; async reset drops any in-flight transaction
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: command phase until accept, response phase for loads only
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture && (i_lsu_op != LSU_IDLE) && !misalign) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (i_SCmdAccept) begin
          state_d = lns_q ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        if (i_SResp != SRESP_NULL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bus command and pipeline stall follow the state directly
  always_comb begin
    o_MCmd      = MCMD_IDLE;
    o_mem_stall = 1'b0;
    case (state_q)
      ST_CMD: begin
        o_MCmd      = lns_q ? MCMD_RD : MCMD_WR;
        o_mem_stall = 1'b1;
      end
      ST_RESP: begin
        o_mem_stall = 1'b1;
      end
      default: begin
        o_MCmd      = MCMD_IDLE;
        o_mem_stall = 1'b0;
      end
    endcase
  end

  // Datapath: request capture, writeback forwarding, response completion, error pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_q      <= 5'd0;
      op_q      <= LSU_IDLE;
      lns_q     <= 1'b0;
      ext_q     <= 1'b0;
      a_q       <= 2'b00;
      maddr_q   <= 32'd0;
      mdata_q   <= 32'd0;
      mbyteen_q <= 4'b0000;
      rd_no_q   <= 5'd0;
      rd_val_q  <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            if (i_lsu_op == LSU_IDLE) begin
              rd_no_q  <= i_rd_no;
              rd_val_q <= i_alu_result;
            end else begin
              // Writeback suppressed until the load completes (stores never write back)
              rd_no_q <= 5'd0;
              if (misalign) begin
                bus_err_q <= 1'b1;
              end else begin
                maddr_q   <= {i_alu_result[31:2], 2'b00};
                mdata_q   <= lane_data;
                mbyteen_q <= lane_be;
                rd_q      <= i_rd_no;
                op_q      <= i_lsu_op;
                lns_q     <= i_lsu_lns;
                ext_q     <= i_lsu_ext;
                a_q       <= a;
              end
            end
          end
        end
        ST_RESP: begin
          if (i_SResp == SRESP_DVA) begin
            rd_val_q <= load_val;
            rd_no_q  <= rd_q;
          end else if (i_SResp != SRESP_NULL) begin
            bus_err_q <= 1'b1;
            rd_no_q   <= 5'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_MAddr   = maddr_q;
  assign o_MData   = mdata_q;
  assign o_MByteEn = mbyteen_q;
  assign o_rd_no   = rd_no_q;
  assign o_rd_val  = rd_val_q;
  assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

  logic        clk;
  logic        nrst;
  logic        i_exec_stall;
  logic        i_fetch_stall;
  logic        o_mem_stall;
  logic [4:0]  i_rd_no;
  logic [31:0] i_alu_result;
  logic [1:0]  i_lsu_op;
  logic        i_lsu_lns;
  logic        i_lsu_ext;
  logic [31:0] i_mem_data;
  logic [4:0]  o_rd_no;
  logic [31:0] o_rd_val;
  logic [31:0] o_MAddr;
  logic [2:0]  o_MCmd;
  logic [31:0] o_MData;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData;
  logic [1:0]  i_SResp;
  logic        o_bus_err;

  int n_cmp;
  int n_err;

  memory_access dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_exec_stall  (i_exec_stall),
    .i_fetch_stall (i_fetch_stall),
    .o_mem_stall   (o_mem_stall),
    .i_rd_no       (i_rd_no),
    .i_alu_result  (i_alu_result),
    .i_lsu_op      (i_lsu_op),
    .i_lsu_lns     (i_lsu_lns),
    .i_lsu_ext     (i_lsu_ext),
    .i_mem_data    (i_mem_data),
    .o_rd_no       (o_rd_no),
    .o_rd_val      (o_rd_val),
    .o_MAddr       (o_MAddr),
    .o_MCmd        (o_MCmd),
    .o_MData       (o_MData),
    .o_MByteEn     (o_MByteEn),
    .i_SCmdAccept  (i_SCmdAccept),
    .i_SData       (i_SData),
    .i_SResp       (i_SResp),
    .o_bus_err     (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle;
    i_exec_stall  = 1'b0;
    i_fetch_stall = 1'b0;
    i_rd_no       = 5'd0;
    i_alu_result  = 32'd0;
    i_lsu_op      = 2'd0;
    i_lsu_lns     = 1'b0;
    i_lsu_ext     = 1'b0;
    i_mem_data    = 32'd0;
    i_SCmdAccept  = 1'b0;
    i_SData       = 32'd0;
    i_SResp       = 2'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    drive_idle();
    tick();
    tick();

    // Reset state
    chk("rst_rd_no",  o_rd_no,     32'd0);
    chk("rst_rd_val", o_rd_val,    32'd0);
    chk("rst_mcmd",   o_MCmd,      32'd0);
    chk("rst_maddr",  o_MAddr,     32'd0);
    chk("rst_mdata",  o_MData,     32'd0);
    chk("rst_mbe",    o_MByteEn,   32'd0);
    chk("rst_stall",  o_mem_stall, 32'd0);
    chk("rst_berr",   o_bus_err,   32'd0);
    nrst = 1'b1;
    tick();

    // 1: ALU pass-through
    i_rd_no = 5'd5; i_alu_result = 32'h1234;
    tick();
    chk("add_rd_no",  o_rd_no,     32'd5);
    chk("add_rd_val", o_rd_val,    32'h1234);
    chk("add_stall",  o_mem_stall, 32'd0);

    // Exec stall blocks capture
    i_exec_stall = 1'b1; i_rd_no = 5'd3; i_alu_result = 32'h33;
    tick();
    chk("xstall_rd_no",  o_rd_no,  32'd5);
    chk("xstall_rd_val", o_rd_val, 32'h1234);
    i_exec_stall = 1'b0;
    tick();
    chk("xrel_rd_no", o_rd_no, 32'd3);

    // 2: SB addr=0x103 d=0xAB, accepted on third command cycle
    i_rd_no = 5'd0; i_alu_result = 32'h103; i_lsu_op = 2'd1; i_lsu_lns = 1'b0; i_mem_data = 32'h0000_00AB;
    tick();
    i_lsu_op = 2'd0; i_rd_no = 5'd7; i_alu_result = 32'h999;
    for (int c = 0; c < 3; c++) begin
      chk("sb_mcmd",  o_MCmd,      32'd1);
      chk("sb_maddr", o_MAddr,     32'h100);
      chk("sb_mbe",   o_MByteEn,   32'h8);
      chk("sb_mdata", o_MData,     32'hABAB_ABAB);
      chk("sb_stall", o_mem_stall, 32'd1);
      if (c == 2) i_SCmdAccept = 1'b1;
      tick();
    end
    i_SCmdAccept = 1'b0;
    chk("sb_done_mcmd",  o_MCmd,      32'd0);
    chk("sb_done_stall", o_mem_stall, 32'd0);
    chk("sb_done_rd_no", o_rd_no,     32'd0);
    tick();
    chk("post_sb_rd_no",  o_rd_no,  32'd7);
    chk("post_sb_rd_val", o_rd_val, 32'h999);

    // SW addr=0x200 accepted at once: single stall cycle
    i_rd_no = 5'd0; i_alu_result = 32'h200; i_lsu_op = 2'd3; i_lsu_lns = 1'b0; i_mem_data = 32'hCAFE_F00D;
    tick();
    drive_idle();
    chk("sw_mcmd",  o_MCmd,    32'd1);
    chk("sw_mbe",   o_MByteEn, 32'hF);
    chk("sw_mdata", o_MData,   32'hCAFE_F00D);
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0;
    chk("sw_done_stall", o_mem_stall, 32'd0);

    // 3a: LH ext=1 addr=0x102; early DVA during command phase must be ignored
    i_rd_no = 5'd9; i_alu_result = 32'h102; i_lsu_op = 2'd2; i_lsu_lns = 1'b1; i_lsu_ext = 1'b1;
    tick();
    drive_idle();
    chk("lh_mcmd",  o_MCmd,      32'd2);
    chk("lh_maddr", o_MAddr,     32'h100);
    chk("lh_mbe",   o_MByteEn,   32'hC);
    chk("lh_stall", o_mem_stall, 32'd1);
    i_SCmdAccept = 1'b1; i_SResp = 2'd1; i_SData = 32'h1111_1111;
    tick();
    i_SCmdAccept = 1'b0;
    chk("lh_resp_mcmd",  o_MCmd,      32'd0);
    chk("lh_resp_stall", o_mem_stall, 32'd1);
    chk("lh_resp_rd_no", o_rd_no,     32'd0);
    i_SResp = 2'd1; i_SData = 32'h8001_0000;
    tick();
    i_SResp = 2'd0;
    chk("lh_rd_no",  o_rd_no,     32'd9);
    chk("lh_rd_val", o_rd_val,    32'hFFFF_8001);
    chk("lh_stall",  o_mem_stall, 32'd0);

    // 3b: LHU ext=0 same address
    i_rd_no = 5'd10; i_alu_result = 32'h102; i_lsu_op = 2'd2; i_lsu_lns = 1'b1; i_lsu_ext = 1'b0;
    tick();
    drive_idle();
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0; i_SResp = 2'd1; i_SData = 32'h8001_0000;
    tick();
    i_SResp = 2'd0;
    chk("lhu_rd_no",  o_rd_no,  32'd10);
    chk("lhu_rd_val", o_rd_val, 32'h0000_8001);

    // LB ext=1 addr=0x101 -> byte lane 1 = 0x80
    i_rd_no = 5'd4; i_alu_result = 32'h101; i_lsu_op = 2'd1; i_lsu_lns = 1'b1; i_lsu_ext = 1'b1;
    tick();
    drive_idle();
    chk("lb_mbe", o_MByteEn, 32'h2);
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0; i_SResp = 2'd1; i_SData = 32'h0000_8000;
    tick();
    i_SResp = 2'd0;
    chk("lb_rd_val", o_rd_val, 32'hFFFF_FF80);

    // 4: LW with ERR response
    i_rd_no = 5'd11; i_alu_result = 32'h200; i_lsu_op = 2'd3; i_lsu_lns = 1'b1;
    tick();
    drive_idle();
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0; i_SResp = 2'd3;
    tick();
    i_SResp = 2'd0;
    chk("err_berr",  o_bus_err,   32'd1);
    chk("err_rd_no", o_rd_no,     32'd0);
    chk("err_stall", o_mem_stall, 32'd0);
    chk("err_mcmd",  o_MCmd,      32'd0);
    tick();
    chk("err_berr_pulse", o_bus_err, 32'd0);

    // 5: async reset while waiting for the response
    i_rd_no = 5'd12; i_alu_result = 32'h300; i_lsu_op = 2'd3; i_lsu_lns = 1'b1;
    tick();
    drive_idle();
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0;
    chk("ar_pre_stall", o_mem_stall, 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("ar_mcmd",  o_MCmd,      32'd0);
    chk("ar_stall", o_mem_stall, 32'd0);
    i_SResp = 2'd1; i_SData = 32'hDEAD_BEEF;
    tick();
    nrst = 1'b1;
    tick();
    i_SResp = 2'd0;
    chk("ar_late_rd_no",  o_rd_no,     32'd0);
    chk("ar_late_rd_val", o_rd_val,    32'd0);
    chk("ar_late_stall",  o_mem_stall, 32'd0);

    // 6: LW at misaligned address 0x102
    i_rd_no = 5'd13; i_alu_result = 32'h102; i_lsu_op = 2'd3; i_lsu_lns = 1'b1;
    tick();
    drive_idle();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_mcmd",  o_MCmd,      32'd0);
    chk("mis_stall", o_mem_stall, 32'd0);
    chk("mis_berr",  o_bus_err,   32'd1);
    chk("mis_rd_no", o_rd_no,     32'd0);
    tick();
    chk("mis_berr_pulse", o_bus_err, 32'd0);
`else
    chk("mis_mcmd",  o_MCmd,    32'd2);
    chk("mis_maddr", o_MAddr,   32'h100);
    chk("mis_mbe",   o_MByteEn, 32'hF);
    i_SCmdAccept = 1'b1;
    tick();
    i_SCmdAccept = 1'b0; i_SResp = 2'd1; i_SData = 32'h1234_5678;
    tick();
    i_SResp = 2'd0;
    chk("mis_rd_no",  o_rd_no,   32'd13);
    chk("mis_rd_val", o_rd_val,  32'h1234_5678);
    chk("mis_berr",   o_bus_err, 32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
